// File: rtl/dual_core_arb_pkg.sv
// Shared types and constants for the dual-core bus arbiter: FSM states, core IDs
// and the read data returned to a core whose bus access timed out.
package dual_core_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_A  = 2'd1,
        GRANT_B  = 2'd2,
        WAIT_REL = 2'd3
    } arb_state_t;

    typedef enum logic {
        CORE_A = 1'b0,
        CORE_B = 1'b1
    } core_id_t;

    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Counts granted cycles without a bus acknowledge and flags when TIMEOUT is reached.
// Only instantiated when DUAL_BUS_ARB_TIMEOUT_EN is defined.
module arb_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    // Saturates at TIMEOUT so a stuck grant cannot wrap and re-arm the timeout.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != CNT_W'(TIMEOUT))) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/dual_bus_arbiter.sv
// Round-robin arbiter sharing one external memory/IO bus between DLX cores PA and PB.
// Optional bus-acknowledge timeout is enabled by defining DUAL_BUS_ARB_TIMEOUT_EN.
module dual_bus_arbiter
    import dual_core_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PA_AS_N,
    input  logic              PA_WR_N,
    input  logic [ADDR_W-1:0] PA_AO,
    input  logic [DATA_W-1:0] PA_DO,
    output logic              PA_ACK_N,
    output logic [DATA_W-1:0] PA_DI,
    input  logic              PB_AS_N,
    input  logic              PB_WR_N,
    input  logic [ADDR_W-1:0] PB_AO,
    input  logic [DATA_W-1:0] PB_DO,
    output logic              PB_ACK_N,
    output logic [DATA_W-1:0] PB_DI,
    output logic              AS_N,
    output logic              WR_N,
    output logic [ADDR_W-1:0] AO,
    output logic [DATA_W-1:0] DO,
    input  logic              ACK_N,
    input  logic [DATA_W-1:0] DI,
    output logic              arb_busy,
    output logic              bus_err
);

    arb_state_t state;
    core_id_t   last_served;
    core_id_t   served;

    logic pick_a;
    logic pick_b;
    logic served_as_n;
    logic in_grant;
    logic timeout_hit;

    // On a tie the core that was not served last wins.
    assign pick_a      = !PA_AS_N && (PB_AS_N || (last_served == CORE_B));
    assign pick_b      = !PB_AS_N && (PA_AS_N || (last_served == CORE_A));
    assign served_as_n = (served == CORE_A) ? PA_AS_N : PB_AS_N;
    assign in_grant    = (state == GRANT_A) || (state == GRANT_B);
    assign arb_busy    = (state != IDLE);

`ifdef DUAL_BUS_ARB_TIMEOUT_EN
    arb_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_grant),
        .enable (in_grant && ACK_N),
        .expired(timeout_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_err <= 1'b0;
        end else if (in_grant && ACK_N && timeout_hit) begin
            bus_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    // Bus fields are loaded once on grant and frozen until the grant ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_served <= CORE_B;
            served      <= CORE_B;
            AS_N        <= 1'b1;
            WR_N        <= 1'b1;
            AO          <= '0;
            DO          <= '0;
            PA_ACK_N    <= 1'b1;
            PB_ACK_N    <= 1'b1;
            PA_DI       <= '0;
            PB_DI       <= '0;
        end else begin
            PA_ACK_N <= 1'b1;
            PB_ACK_N <= 1'b1;
            case (state)
                IDLE: begin
                    if (pick_a) begin
                        state  <= GRANT_A;
                        served <= CORE_A;
                        AS_N   <= 1'b0;
                        WR_N   <= PA_WR_N;
                        AO     <= PA_AO;
                        DO     <= PA_DO;
                    end else if (pick_b) begin
                        state  <= GRANT_B;
                        served <= CORE_B;
                        AS_N   <= 1'b0;
                        WR_N   <= PB_WR_N;
                        AO     <= PB_AO;
                        DO     <= PB_DO;
                    end
                end
                GRANT_A, GRANT_B: begin
                    // A real acknowledge takes priority over a simultaneous timeout.
                    if (!ACK_N || timeout_hit) begin
                        AS_N        <= 1'b1;
                        WR_N        <= 1'b1;
                        last_served <= served;
                        state       <= WAIT_REL;
                        if (served == CORE_A) begin
                            PA_ACK_N <= 1'b0;
                            PA_DI    <= !ACK_N ? DI : DATA_W'(ERR_DATA);
                        end else begin
                            PB_ACK_N <= 1'b0;
                            PB_DI    <= !ACK_N ? DI : DATA_W'(ERR_DATA);
                        end
                    end
                end
                WAIT_REL: begin
                    if (served_as_n) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dual_bus_arbiter.sv
// Directed self-checking bench for dual_bus_arbiter; the timeout scenario follows
// DUAL_BUS_ARB_TIMEOUT_EN so the bench matches whichever build it is compiled with.
module tb_dual_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        PA_AS_N, PA_WR_N, PB_AS_N, PB_WR_N;
    logic [31:0] PA_AO, PA_DO, PB_AO, PB_DO;
    logic        PA_ACK_N, PB_ACK_N;
    logic [31:0] PA_DI, PB_DI;
    logic        AS_N, WR_N;
    logic [31:0] AO, DO;
    logic        ACK_N;
    logic [31:0] DI;
    logic        arb_busy, bus_err;

    int checks = 0;
    int errors = 0;

    dual_bus_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .PA_AS_N (PA_AS_N),
        .PA_WR_N (PA_WR_N),
        .PA_AO   (PA_AO),
        .PA_DO   (PA_DO),
        .PA_ACK_N(PA_ACK_N),
        .PA_DI   (PA_DI),
        .PB_AS_N (PB_AS_N),
        .PB_WR_N (PB_WR_N),
        .PB_AO   (PB_AO),
        .PB_DO   (PB_DO),
        .PB_ACK_N(PB_ACK_N),
        .PB_DI   (PB_DI),
        .AS_N    (AS_N),
        .WR_N    (WR_N),
        .AO      (AO),
        .DO      (DO),
        .ACK_N   (ACK_N),
        .DI      (DI),
        .arb_busy(arb_busy),
        .bus_err (bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        PA_AS_N = 1'b1; PA_WR_N = 1'b1; PA_AO = '0; PA_DO = '0;
        PB_AS_N = 1'b1; PB_WR_N = 1'b1; PB_AO = '0; PB_DO = '0;
        ACK_N = 1'b1; DI = '0;
        do_reset();
        checks++; if (AS_N !== 1'b1) begin errors++; $display("[TB] FAIL reset_as_n: got %b expected 1", AS_N); end
        checks++; if (WR_N !== 1'b1) begin errors++; $display("[TB] FAIL reset_wr_n: got %b expected 1", WR_N); end
        checks++; if (AO !== 32'h0) begin errors++; $display("[TB] FAIL reset_ao: got %h expected 0", AO); end
        checks++; if (DO !== 32'h0) begin errors++; $display("[TB] FAIL reset_do: got %h expected 0", DO); end
        checks++; if (PA_ACK_N !== 1'b1 || PB_ACK_N !== 1'b1) begin errors++; $display("[TB] FAIL reset_acks: got %b%b expected 11", PA_ACK_N, PB_ACK_N); end
        checks++; if (PA_DI !== 32'h0 || PB_DI !== 32'h0) begin errors++; $display("[TB] FAIL reset_di: got %h/%h expected 0/0", PA_DI, PB_DI); end
        checks++; if (arb_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", arb_busy); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_err: got %b expected 0", bus_err); end
    endtask

    task automatic test_pa_read();
        PA_AS_N = 1'b0; PA_WR_N = 1'b1; PA_AO = 32'h40;
        tick();
        checks++; if (AS_N !== 1'b0) begin errors++; $display("[TB] FAIL read_grant_as_n: got %b expected 0", AS_N); end
        checks++; if (AO !== 32'h40 || WR_N !== 1'b1) begin errors++; $display("[TB] FAIL read_bus: got ao=%h wr_n=%b expected ao=40 wr_n=1", AO, WR_N); end
        checks++; if (arb_busy !== 1'b1) begin errors++; $display("[TB] FAIL read_busy: got %b expected 1", arb_busy); end
        tick();
        tick();
        checks++; if (PA_ACK_N !== 1'b1 || AS_N !== 1'b0) begin errors++; $display("[TB] FAIL read_wait: got ack_n=%b as_n=%b expected 1 0", PA_ACK_N, AS_N); end
        ACK_N = 1'b0; DI = 32'h1234;
        tick();
        checks++; if (PA_ACK_N !== 1'b0) begin errors++; $display("[TB] FAIL read_pa_ack: got %b expected 0", PA_ACK_N); end
        checks++; if (PA_DI !== 32'h1234) begin errors++; $display("[TB] FAIL read_pa_di: got %h expected 00001234", PA_DI); end
        checks++; if (AS_N !== 1'b1) begin errors++; $display("[TB] FAIL read_release_as_n: got %b expected 1", AS_N); end
        checks++; if (PB_ACK_N !== 1'b1) begin errors++; $display("[TB] FAIL read_pb_ack: got %b expected 1", PB_ACK_N); end
        ACK_N = 1'b1; DI = '0; PA_AS_N = 1'b1;
        tick();
        checks++; if (PA_ACK_N !== 1'b1) begin errors++; $display("[TB] FAIL read_ack_pulse_width: got %b expected 1", PA_ACK_N); end
        checks++; if (arb_busy !== 1'b0) begin errors++; $display("[TB] FAIL read_back_idle: got %b expected 0", arb_busy); end
    endtask

    task automatic test_tie();
        do_reset();
        PA_AS_N = 1'b0; PA_AO = 32'hA0;
        PB_AS_N = 1'b0; PB_AO = 32'hB0;
        tick();
        checks++; if (AO !== 32'hA0 || AS_N !== 1'b0) begin errors++; $display("[TB] FAIL tie_first_pa: got ao=%h as_n=%b expected a0 0", AO, AS_N); end
        ACK_N = 1'b0; DI = 32'h11;
        tick();
        checks++; if (PA_ACK_N !== 1'b0 || PB_ACK_N !== 1'b1) begin errors++; $display("[TB] FAIL tie_pa_ack: got %b%b expected 01", PA_ACK_N, PB_ACK_N); end
        ACK_N = 1'b1; PA_AS_N = 1'b1;
        tick();
        checks++; if (AS_N !== 1'b1 || arb_busy !== 1'b0) begin errors++; $display("[TB] FAIL tie_turnaround: got as_n=%b busy=%b expected 1 0", AS_N, arb_busy); end
        tick();
        checks++; if (AO !== 32'hB0 || AS_N !== 1'b0) begin errors++; $display("[TB] FAIL tie_then_pb: got ao=%h as_n=%b expected b0 0", AO, AS_N); end
        ACK_N = 1'b0; DI = 32'h55;
        tick();
        checks++; if (PB_ACK_N !== 1'b0 || PB_DI !== 32'h55 || PA_ACK_N !== 1'b1) begin errors++; $display("[TB] FAIL tie_pb_ack: got pb=%b di=%h pa=%b expected 0 55 1", PB_ACK_N, PB_DI, PA_ACK_N); end
        ACK_N = 1'b1; PB_AS_N = 1'b1;
        tick();
        PA_AS_N = 1'b0; PB_AS_N = 1'b0;
        tick();
        checks++; if (AO !== 32'hA0 || AS_N !== 1'b0) begin errors++; $display("[TB] FAIL tie_second_pa: got ao=%h as_n=%b expected a0 0", AO, AS_N); end
        ACK_N = 1'b0;
        tick();
        ACK_N = 1'b1; PA_AS_N = 1'b1; PB_AS_N = 1'b1;
        tick();
    endtask

    task automatic test_pb_write();
        PB_AS_N = 1'b0; PB_WR_N = 1'b0; PB_AO = 32'h10; PB_DO = 32'hCAFE0001;
        tick();
        checks++; if (AS_N !== 1'b0 || WR_N !== 1'b0) begin errors++; $display("[TB] FAIL write_grant: got as_n=%b wr_n=%b expected 0 0", AS_N, WR_N); end
        PB_AO = 32'h99; PB_DO = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (AO !== 32'h10 || DO !== 32'hCAFE0001 || WR_N !== 1'b0) begin errors++; $display("[TB] FAIL write_frozen[%0d]: got ao=%h do=%h wr_n=%b expected 10 cafe0001 0", i, AO, DO, WR_N); end
        end
        ACK_N = 1'b0;
        tick();
        checks++; if (PB_ACK_N !== 1'b0 || AS_N !== 1'b1 || WR_N !== 1'b1) begin errors++; $display("[TB] FAIL write_ack: got ack_n=%b as_n=%b wr_n=%b expected 0 1 1", PB_ACK_N, AS_N, WR_N); end
        ACK_N = 1'b1; PB_AS_N = 1'b1; PB_WR_N = 1'b1;
        tick();
    endtask

    task automatic test_hold_release();
        PA_AS_N = 1'b0; PA_AO = 32'h70; PB_AO = 32'h20;
        tick();
        ACK_N = 1'b0;
        tick();
        checks++; if (PA_ACK_N !== 1'b0) begin errors++; $display("[TB] FAIL hold_pa_ack: got %b expected 0", PA_ACK_N); end
        PB_AS_N = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (AS_N !== 1'b1 || arb_busy !== 1'b1 || PA_ACK_N !== 1'b1 || PB_ACK_N !== 1'b1) begin errors++; $display("[TB] FAIL hold_wait_rel[%0d]: got as_n=%b busy=%b acks=%b%b expected 1 1 11", i, AS_N, arb_busy, PA_ACK_N, PB_ACK_N); end
        end
        ACK_N = 1'b1; PA_AS_N = 1'b1;
        tick();
        checks++; if (AS_N !== 1'b1 || arb_busy !== 1'b0) begin errors++; $display("[TB] FAIL hold_idle: got as_n=%b busy=%b expected 1 0", AS_N, arb_busy); end
        tick();
        checks++; if (AS_N !== 1'b0 || AO !== 32'h20) begin errors++; $display("[TB] FAIL hold_pb_grant: got as_n=%b ao=%h expected 0 20", AS_N, AO); end
        ACK_N = 1'b0;
        tick();
        checks++; if (PB_ACK_N !== 1'b0 || PA_ACK_N !== 1'b1) begin errors++; $display("[TB] FAIL hold_pb_ack: got pb=%b pa=%b expected 0 1", PB_ACK_N, PA_ACK_N); end
        ACK_N = 1'b1; PB_AS_N = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        PB_AS_N = 1'b0; PB_AO = 32'h30;
        tick();
        checks++; if (AS_N !== 1'b0 || AO !== 32'h30) begin errors++; $display("[TB] FAIL rmid_grant: got as_n=%b ao=%h expected 0 30", AS_N, AO); end
        tick();
        reset = 1'b1; ACK_N = 1'b0;
        tick();
        reset = 1'b0; PB_AS_N = 1'b1;
        checks++; if (AS_N !== 1'b1 || arb_busy !== 1'b0 || PA_ACK_N !== 1'b1 || PB_ACK_N !== 1'b1) begin errors++; $display("[TB] FAIL rmid_released: got as_n=%b busy=%b acks=%b%b expected 1 0 11", AS_N, arb_busy, PA_ACK_N, PB_ACK_N); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (PB_ACK_N !== 1'b1 || PA_ACK_N !== 1'b1 || arb_busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_no_ack[%0d]: got acks=%b%b busy=%b expected 11 0", i, PA_ACK_N, PB_ACK_N, arb_busy); end
            ACK_N = 1'b1;
        end
    endtask

    task automatic test_timeout();
        do_reset();
        PA_AS_N = 1'b0; PA_AO = 32'h80;
        tick();
        checks++; if (AS_N !== 1'b0) begin errors++; $display("[TB] FAIL to_grant: got %b expected 0", AS_N); end
`ifdef DUAL_BUS_ARB_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++; if (PA_ACK_N !== 1'b1 || AS_N !== 1'b0) begin errors++; $display("[TB] FAIL to_early[%0d]: got ack_n=%b as_n=%b expected 1 0", i, PA_ACK_N, AS_N); end
        end
        tick();
        checks++; if (PA_ACK_N !== 1'b0 || PA_DI !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL to_fire: got ack_n=%b di=%h expected 0 deadbeef", PA_ACK_N, PA_DI); end
        checks++; if (AS_N !== 1'b1 || bus_err !== 1'b1) begin errors++; $display("[TB] FAIL to_err: got as_n=%b bus_err=%b expected 1 1", AS_N, bus_err); end
        PA_AS_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus_err !== 1'b1 || PA_ACK_N !== 1'b1) begin errors++; $display("[TB] FAIL to_sticky[%0d]: got bus_err=%b ack_n=%b expected 1 1", i, bus_err, PA_ACK_N); end
        end
        do_reset();
        checks++; if (bus_err !== 1'b0) begin errors++; $display("[TB] FAIL to_err_cleared: got %b expected 0", bus_err); end
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (PA_ACK_N !== 1'b1 || AS_N !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("[TB] FAIL no_to_wait[%0d]: got ack_n=%b as_n=%b bus_err=%b expected 1 0 0", i, PA_ACK_N, AS_N, bus_err); end
        end
        PA_AS_N = 1'b1;
        do_reset();
        checks++; if (AS_N !== 1'b1 || arb_busy !== 1'b0) begin errors++; $display("[TB] FAIL no_to_reset: got as_n=%b busy=%b expected 1 0", AS_N, arb_busy); end
`endif
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_pa_read();
        test_tie();
        test_pb_write();
        test_hold_release();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
